// File: rtl/fifo_traffic_engine.sv
// FIFO traffic engine: writes an incrementing word stream into a FIFO and/or reads
// one back, checking each word, with stall timeout and run statistics.
module fifo_traffic_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    input  logic                  fifo_full,
    input  logic                  fifo_mty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_mode;
    logic [CNT_WIDTH-1:0]  r_wr_rem, r_rd_rem;
    logic [DATA_WIDTH-1:0] r_wr_word, r_chk_word;
    logic                  r_pend;
    logic [SW-1:0]         r_stall;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_err_cnt, r_wr_cnt, r_rd_cnt;

    logic w_accept, w_wr_left, w_rd_left, w_stall_hit;
    logic w_wr_go, w_rd_go, w_wr_last, w_rd_last, w_abort;

    assign w_accept    = start && (mode != 2'b00) && (count != '0);
    assign w_wr_left   = r_mode[0] && (r_wr_rem != '0);
    assign w_rd_left   = r_mode[1] && (r_rd_rem != '0);
    assign w_stall_hit = (r_stall == SW'(TIMEOUT_CYCLES));
    assign w_abort     = (r_state == S_RUN) && w_stall_hit;
    assign w_wr_go     = (r_state == S_RUN) && !w_stall_hit && w_wr_left && !fifo_full;
    assign w_rd_go     = (r_state == S_RUN) && !w_stall_hit && w_rd_left && !fifo_mty;
    // A side is finished once it has nothing left after this cycle's transfer.
    assign w_wr_last   = !w_wr_left || (w_wr_go && (r_wr_rem == CNT_WIDTH'(1)));
    assign w_rd_last   = !w_rd_left || (w_rd_go && (r_rd_rem == CNT_WIDTH'(1)));

    assign timeout = r_timeout;
    assign err_cnt = r_err_cnt;
    assign wr_cnt  = r_wr_cnt;
    assign rd_cnt  = r_rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        fifo_wr   = w_wr_go;
        fifo_rd   = w_rd_go;
        fifo_data = w_wr_go ? r_wr_word : '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_stall_hit)              w_next = S_DONE;
                else if (w_wr_last && w_rd_last) w_next = w_rd_go ? S_FLUSH : S_DONE;
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= '0;
            r_wr_rem   <= '0;
            r_rd_rem   <= '0;
            r_wr_word  <= '0;
            r_chk_word <= '0;
            r_pend     <= 1'b0;
            r_stall    <= '0;
            r_timeout  <= 1'b0;
            r_err_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_mode     <= mode;
            r_wr_rem   <= count;
            r_rd_rem   <= count;
            r_wr_word  <= seed;
            r_chk_word <= seed;
            r_pend     <= 1'b0;
            r_stall    <= '0;
            r_timeout  <= 1'b0;
            r_err_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            if (w_wr_go) begin
                r_wr_rem  <= r_wr_rem - CNT_WIDTH'(1);
                r_wr_word <= r_wr_word + DATA_WIDTH'(1);
                r_wr_cnt  <= r_wr_cnt + CNT_WIDTH'(1);
            end
            if (w_rd_go) r_rd_rem <= r_rd_rem - CNT_WIDTH'(1);
            // fifo_q is valid the cycle after a read was issued.
            r_pend <= w_rd_go;
            if (r_pend) begin
                r_rd_cnt   <= r_rd_cnt + CNT_WIDTH'(1);
                r_chk_word <= r_chk_word + DATA_WIDTH'(1);
                if ((fifo_q != r_chk_word) && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            if (r_state != S_RUN)        r_stall <= '0;
            else if (w_wr_go || w_rd_go) r_stall <= '0;
            else                         r_stall <= r_stall + SW'(1);
            if (w_abort) r_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_traffic_engine.sv
// Self-checking bench for fifo_traffic_engine: table of runs against a depth-16 FIFO
// model, plus hand sequences for preload mismatch, stuck-full timeout, reset and ignored starts.
module tb_fifo_traffic_engine;
    localparam int TO = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] count = '0;
    logic [7:0]  seed = '0;
    logic        fifo_wr, fifo_rd, fifo_full, fifo_mty;
    logic [7:0]  fifo_data;
    logic [7:0]  fifo_q = '0;
    logic        busy, done, timeout;
    logic [15:0] err_cnt, wr_cnt, rd_cnt;

    fifo_traffic_engine #(.DATA_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count), .seed(seed),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .fifo_full(fifo_full), .fifo_mty(fifo_mty), .fifo_q(fifo_q),
        .busy(busy), .done(done), .timeout(timeout),
        .err_cnt(err_cnt), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Depth-16 FIFO model with registered read data; ovr replays a fixed preload table.
    logic [7:0] mq[$];
    logic [7:0] pre[4];
    logic [1:0] pi = '0;
    int         occ = 0;
    logic       clr_req = 1'b0, ovr = 1'b0, force_full = 1'b0;

    assign fifo_full = force_full || (occ >= 16);
    assign fifo_mty  = ovr ? 1'b0 : (occ == 0);

    always @(posedge clk) begin
        if (clr_req) begin
            mq.delete();
            pi  <= '0;
            occ <= 0;
        end else if (ovr) begin
            if (fifo_rd) begin
                fifo_q <= pre[pi];
                pi     <= pi + 2'd1;
            end
        end else begin
            if (fifo_rd && mq.size() > 0) fifo_q <= mq.pop_front();
            if (fifo_wr) mq.push_back(fifo_data);
            occ <= mq.size();
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0]  exp_wr[$];
    int          busy_cyc;
    bit          saw_done, data_bad, last_idle, pre_done_idle;
    logic [15:0] o_wr, o_rd, o_err;
    logic        o_to;

    task automatic run(input logic [1:0] m, input int n, input logic [7:0] s, input bit mid);
        exp_wr.delete();
        if (m[0]) for (int k = 0; k < n; k++) exp_wr.push_back(s + 8'(k));
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        mode = m; count = 16'(n); seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0; saw_done = 0; data_bad = 0; last_idle = 0; pre_done_idle = 0;
        for (int c = 0; c < 20000 && !saw_done; c++) begin
            if (done) begin
                saw_done = 1;
                pre_done_idle = last_idle;
                o_wr = wr_cnt; o_rd = rd_cnt; o_err = err_cnt; o_to = timeout;
            end else begin
                if (busy) busy_cyc++;
                last_idle = busy && !fifo_wr && !fifo_rd;
                if (fifo_wr) begin
                    if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
                    else chk("wr_data", 32'(fifo_data), 32'(exp_wr.pop_front()));
                end else if (fifo_data != 8'h00) data_bad = 1;
                if (mid && c == 2) begin
                    start = 1'b1; mode = 2'b11; count = 16'd99; seed = 8'h55;
                end else start = 1'b0;
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(saw_done), 1);
        chk("data_zero_when_idle", 32'(data_bad), 0);
        @(negedge clk);
        chk("done_one_cycle", {30'd0, done, busy}, 0);
        chk("wr_cnt_hold", 32'(wr_cnt), 32'(o_wr));
    endtask

    typedef struct {
        logic [1:0] m;
        int         n;
        logic [7:0] s;
        int         e_wr, e_rd, e_err, e_to, e_left, e_busy;
    } vec_t;
    vec_t vt[4];

    initial begin
        vt[0] = '{2'b01,   4, 8'hF0,   4,   0, 0, 0, 0,    4};
        vt[1] = '{2'b11, 300, 8'hFE, 300, 300, 0, 0, 0,  302};
        vt[2] = '{2'b11,  20, 8'h00,  20,  20, 0, 0, 0,   22};
        vt[3] = '{2'b01,  20, 8'h07,  16,   0, 0, 1, 4, TO + 17};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fifo_ctl", {29'd0, fifo_wr, fifo_rd, timeout}, 0);
        chk("rst_fifo_data", 32'(fifo_data), 0);
        chk("rst_cnts", {err_cnt, wr_cnt | rd_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run(vt[i].m, vt[i].n, vt[i].s, 1'b0);
            chk("vec_wr_cnt", 32'(o_wr), 32'(vt[i].e_wr));
            chk("vec_rd_cnt", 32'(o_rd), 32'(vt[i].e_rd));
            chk("vec_err_cnt", 32'(o_err), 32'(vt[i].e_err));
            chk("vec_timeout", 32'(o_to), 32'(vt[i].e_to));
            chk("vec_wr_left", 32'(exp_wr.size()), 32'(vt[i].e_left));
            chk("vec_busy_cycles", 32'(busy_cyc), 32'(vt[i].e_busy));
        end

        // Preloaded FIFO with one corrupt word; last compare lands in FLUSH.
        pre[0] = 8'h10; pre[1] = 8'h11; pre[2] = 8'h99; pre[3] = 8'h00;
        ovr = 1'b1;
        run(2'b10, 3, 8'h10, 1'b0);
        ovr = 1'b0;
        chk("pre_err_cnt", 32'(o_err), 1);
        chk("pre_rd_cnt", 32'(o_rd), 3);
        chk("pre_flush_before_done", 32'(pre_done_idle), 1);
        chk("pre_busy_cycles", 32'(busy_cyc), 4);

        // Stuck full: TO stalled cycles, then the abort cycle.
        force_full = 1'b1;
        run(2'b01, 5, 8'h00, 1'b0);
        force_full = 1'b0;
        chk("stuck_timeout", 32'(o_to), 1);
        chk("stuck_wr_cnt", 32'(o_wr), 0);
        chk("stuck_busy_cycles", 32'(busy_cyc), TO + 1);
        chk("timeout_holds", 32'(timeout), 1);

        // Start while busy is ignored: stream follows original parameters.
        run(2'b01, 10, 8'h30, 1'b1);
        chk("busy_start_wr_cnt", 32'(o_wr), 10);
        chk("busy_start_busy_cycles", 32'(busy_cyc), 10);
        chk("busy_start_no_rerun", {30'd0, busy, done}, 0);

        // Invalid starts in IDLE.
        data_bad = 0;
        mode = 2'b01; count = 16'd0; seed = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            if (busy || done || fifo_wr) data_bad = 1;
            @(negedge clk);
        end
        mode = 2'b00; count = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            if (busy || done || fifo_wr) data_bad = 1;
            @(negedge clk);
        end
        chk("ignored_starts", 32'(data_bad), 0);
        chk("ignored_keeps_wr_cnt", 32'(wr_cnt), 10);

        // Asynchronous reset mid-run.
        mode = 2'b11; count = 16'd300; seed = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {28'd0, fifo_wr, fifo_rd, busy, done}, 0);
        chk("rst_mid_cnts", {err_cnt | rd_cnt, wr_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, fifo_wr}, 0);
        run(2'b11, 30, 8'h55, 1'b0);
        chk("post_rst_rd_cnt", 32'(o_rd), 30);
        chk("post_rst_err_cnt", 32'(o_err), 0);
        chk("post_rst_timeout", 32'(o_to), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_traffic_engine.md
FIFO_TRAFFIC_ENGINE -- requirements
Module: fifo_traffic_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO data words.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of transfer counters and the count input.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 3000, consecutive stalled cycles before abort.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk input 1, rst input 1.
REQ-005 SHALL have: start input 1, one-cycle pulse that launches a run when idle.
REQ-006 SHALL have: mode input 2, bit0 = write side enabled, bit1 = read/check side enabled, sampled on start.
REQ-007 SHALL have: count input CNT_WIDTH, words per enabled side, sampled on start.
REQ-008 SHALL have: seed input DATA_WIDTH, first data word, sampled on start.
REQ-009 SHALL have: fifo_wr output 1, fifo_data output DATA_WIDTH, fifo_rd output 1, fifo_full input 1, fifo_mty input 1, fifo_q input DATA_WIDTH.
REQ-010 SHALL have: busy output 1, done output 1, timeout output 1, err_cnt output CNT_WIDTH, wr_cnt output CNT_WIDTH, rd_cnt output CNT_WIDTH.

Function
REQ-011 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-012 IDLE: start=1 with mode!=0 and count!=0 SHALL register mode/count/seed, clear err_cnt, wr_cnt, rd_cnt and timeout, and go to RUN next cycle; otherwise start SHALL be ignored.
REQ-013 start while not IDLE SHALL be ignored.
REQ-014 Word k (k = 0..count-1) SHALL equal (seed + k) mod 2^DATA_WIDTH for both the write generator and the read checker.
REQ-015 RUN, write side: fifo_wr SHALL be 1 in every cycle where mode[0]=1, writes remaining > 0 and fifo_full=0, with fifo_data = next word; back-to-back writes allowed; wr_cnt increments per write.
REQ-016 RUN, read side: fifo_rd SHALL be 1 in every cycle where mode[1]=1, reads remaining > 0 and fifo_mty=0; back-to-back reads allowed.
REQ-017 fifo_q SHALL be sampled exactly one cycle after each fifo_rd cycle and compared with the expected word; rd_cnt increments per sample; a mismatch SHALL increment err_cnt, saturating at all-ones.
REQ-018 fifo_wr and fifo_rd MAY assert in the same cycle; both sides SHALL progress independently.
REQ-019 When all enabled sides have zero remaining, RUN SHALL go to FLUSH if a read sample is pending, else to DONE.
REQ-020 FLUSH SHALL last one cycle, perform the final compare, then go to DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, then go to IDLE; busy SHALL be 1 in RUN and FLUSH only.
REQ-022 Stall counter SHALL increment each RUN cycle where no fifo_wr and no fifo_rd is issued while work remains, and clear on any transfer.
REQ-023 Stall counter reaching TIMEOUT_CYCLES SHALL set timeout=1, deassert fifo_wr/fifo_rd in that cycle, complete any pending sample, and go to DONE; timeout holds until next accepted start.
REQ-024 fifo_data SHALL be 0 whenever fifo_wr=0.
REQ-025 Counters SHALL be CNT_WIDTH wide; wr_cnt, rd_cnt and err_cnt hold their values after DONE until the next accepted start.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, fifo_wr=0, fifo_rd=0, fifo_data=0, busy=0, done=0, timeout=0, err_cnt=0, wr_cnt=0, rd_cnt=0, and clear the stall counter and pending sample.
REQ-027 rst asserted mid-run SHALL abort with no further FIFO accesses; the first cycle after deassertion is IDLE.

Verification
REQ-028 mode=01, count=4, seed=8'hF0, full=0 -> fifo_wr high 4 consecutive cycles, data F0,F1,F2,F3; done pulse; wr_cnt=4.
REQ-029 mode=11, count=300, seed=8'hFE, connected to correct depth-16 FIFO -> data wraps FE,FF,00,...; done; rd_cnt=300, err_cnt=0, timeout=0.
REQ-030 mode=10, count=3, FIFO preloaded 10,11,99, seed=8'h10 -> err_cnt=1, rd_cnt=3, FLUSH visited one cycle before done.
REQ-031 mode=01, count=5, fifo_full stuck 1, TIMEOUT_CYCLES=3000 -> timeout=1 and done after exactly 3000 stalled cycles, wr_cnt=0.
REQ-032 rst pulsed during a mode=11 run -> fifo_wr, fifo_rd, busy drop immediately; all counters 0; next start runs normally.
REQ-033 start with count=0 or mode=00, and start while busy -> ignored, busy stays as before, no done pulse.
